// File: rtl/traffic_pkg.sv
// Shared defaults and debounce state encoding for the traffic-light front end.
package traffic_pkg;

    localparam int N_SW_DEFAULT            = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } deb_state_e;

endpackage

// File: rtl/switch_conditioner_debounce_ch.sv
// Single-channel two-flop synchroniser plus debounce FSM producing a clean level
// and a one-cycle pulse on every accepted rising transition.
module debounce_ch
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            s1_q    <= sw_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    // Counter restarts on every reversal, so it never passes CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (s2_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (!s2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s2_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (s2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = (state_q == STABLE_HI) || (state_q == WAIT_LO);
    assign rise  = rise_q;

endmodule

// File: rtl/switch_conditioner.sv
// Synchronises and debounces the board switches feeding the traffic-light FSM.
// Optional sticky request flags are built when SWITCH_CONDITIONER_STICKY_REQ_EN is defined.
module switch_conditioner
    import traffic_pkg::*;
#(
    parameter int N_SW            = N_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    input  logic [N_SW-1:0] req_clr,
    output logic [N_SW-1:0] switches,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] req_pend
);

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .sw_raw(sw_raw[i]),
            .level (switches[i]),
            .rise  (sw_rise[i])
        );
    end

`ifdef SWITCH_CONDITIONER_STICKY_REQ_EN
    logic [N_SW-1:0] req_pend_q, req_pend_d;

    // A new rise outranks a simultaneous acknowledge so no request is dropped.
    assign req_pend_d = sw_rise | (req_pend_q & ~req_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_pend_q <= '0;
        end else begin
            req_pend_q <= req_pend_d;
        end
    end

    assign req_pend = req_pend_q;
`else
    logic unused_req_clr;
    assign unused_req_clr = ^req_clr;
    assign req_pend       = '0;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with an 8-cycle debounce; follows SWITCH_CONDITIONER_STICKY_REQ_EN.
module tb_switch_conditioner;

    localparam int D = 8;
    // Steps from the capture edge (step 1) up to the accepting edge (E+D+1).
    localparam int ACCEPT_STEPS = D + 2;

    logic       clk;
    logic       reset;
    logic [3:0] sw_raw;
    logic [3:0] req_clr;
    logic [3:0] switches;
    logic [3:0] sw_rise;
    logic [3:0] req_pend;

    int checks = 0;
    int errors = 0;

    // Reference: input delayed two samples; a level flips once D consecutive
    // delayed samples disagree with it.
    logic [3:0] m_p1, m_p2, m_level, m_rise, m_pend;
    int         run [4];

    switch_conditioner #(
        .N_SW           (4),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_raw  (sw_raw),
        .req_clr (req_clr),
        .switches(switches),
        .sw_rise (sw_rise),
        .req_pend(req_pend)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        logic [3:0] rise_n;
        rise_n = '0;
        if (!reset) begin
            m_p1 = '0; m_p2 = '0; m_level = '0; m_rise = '0; m_pend = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_p2[i] !== m_level[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        m_level[i] = ~m_level[i];
                        run[i]     = 0;
                        rise_n[i]  = m_level[i];
                    end
                end else begin
                    run[i] = 0;
                end
            end
`ifdef SWITCH_CONDITIONER_STICKY_REQ_EN
            m_pend = m_rise | (m_pend & ~req_clr);
`endif
            m_rise = rise_n;
            m_p2   = m_p1;
            m_p1   = sw_raw;
        end
        @(posedge clk);
        @(negedge clk);
        chk("model_switches", switches, m_level);
        chk("model_sw_rise",  sw_rise,  m_rise);
        chk("model_req_pend", req_pend, m_pend);
    endtask

    task automatic wait_sw(input int ch, input logic val, input int bound,
                           output int n, output int rises);
        n = 0;
        rises = 0;
        do begin
            step();
            n++;
            rises += int'(sw_rise[ch]);
        end while (switches[ch] !== val && n < bound);
    endtask

    typedef struct {
        logic [3:0] raw;
        int         n;
        logic [3:0] exp_sw;
    } vec_t;

    initial begin
        vec_t tbl [8];
        int   n, r, seen;

        for (int i = 0; i < 4; i++) run[i] = 0;
        m_p1 = '0; m_p2 = '0; m_level = '0; m_rise = '0; m_pend = '0;

        // Reset held with all switches high
        reset = 1'b0; sw_raw = 4'b1111; req_clr = '0;
        repeat (5) step();
        chk("rst_switches", switches, 4'b0000);
        chk("rst_sw_rise", sw_rise, 4'b0000);
        chk("rst_req_pend", req_pend, 4'b0000);
        reset = 1'b1;
        repeat (ACCEPT_STEPS - 1) step();
        chk("rel_before_accept", switches, 4'b0000);
        step();
        chk("rel_accept_sw", switches, 4'b1111);
        chk("rel_accept_rise", sw_rise, 4'b1111);
        step();
        chk("rel_rise_one_cycle", sw_rise, 4'b0000);
`ifdef SWITCH_CONDITIONER_STICKY_REQ_EN
        chk("rel_pend_set", req_pend, 4'b1111);
        req_clr = 4'b1111;
        step();
        req_clr = '0;
`else
        chk("rel_pend_tied", req_pend, 4'b0000);
`endif
        sw_raw = '0;
        repeat (12) step();
        chk("settle_low", switches, 4'b0000);

        // Bounce on ch0: 3-cycle high pulses
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            sw_raw[0] = ((c % 6) < 3);
            step();
            seen |= int'(switches[0]) | int'(sw_rise[0]);
        end
        chk("bounce_rejected", seen, 0);
        sw_raw = '0;
        repeat (12) step();

        // Clean press and release on ch2
        sw_raw[2] = 1'b1;
        wait_sw(2, 1'b1, 30, n, r);
        chk("press_latency", n, ACCEPT_STEPS);
        chk("press_rise_count", r, 1);
        r = 0;
        repeat (20 - n) begin
            step();
            r += int'(sw_rise[2]);
        end
        chk("hold_no_rise", r, 0);
        sw_raw[2] = 1'b0;
        wait_sw(2, 1'b0, 30, n, r);
        chk("release_latency", n, ACCEPT_STEPS);
        chk("release_no_rise", r, 0);

        // Near miss on ch1: 7 stable samples rejected, 8 accepted
        seen = 0;
        sw_raw[1] = 1'b1;
        repeat (7) begin step(); seen |= int'(switches[1]); end
        sw_raw[1] = 1'b0;
        repeat (20) begin step(); seen |= int'(switches[1]); end
        chk("near_miss_7", seen, 0);
        sw_raw[1] = 1'b1;
        repeat (8) begin step(); seen |= int'(switches[1]); end
        sw_raw[1] = 1'b0;
        repeat (4) begin step(); seen |= int'(switches[1]); end
        chk("accept_8", seen, 1);
        repeat (12) step();

        // Reset with ch0 mid-debounce
        sw_raw[0] = 1'b1;
        repeat (7) step();
        reset = 1'b0;
        repeat (2) step();
        chk("midrst_sw0", switches[0], 1'b0);
        reset = 1'b1;
        wait_sw(0, 1'b1, 30, n, r);
        chk("midrst_latency", n, ACCEPT_STEPS);
        chk("midrst_rise", r, 1);

        // Sticky request on ch3
        sw_raw[3] = 1'b1;
        wait_sw(3, 1'b1, 30, n, r);
        step();
`ifdef SWITCH_CONDITIONER_STICKY_REQ_EN
        chk("sticky_set", req_pend[3], 1'b1);
        repeat (50) step();
        chk("sticky_hold", req_pend[3], 1'b1);
        req_clr[3] = 1'b1;
        step();
        req_clr[3] = 1'b0;
        chk("sticky_clear", req_pend[3], 1'b0);
        sw_raw[3] = 1'b0;
        wait_sw(3, 1'b0, 30, n, r);
        sw_raw[3] = 1'b1;
        wait_sw(3, 1'b1, 30, n, r);
        chk("coincide_rise", sw_rise[3], 1'b1);
        req_clr[3] = 1'b1;
        step();
        req_clr[3] = 1'b0;
        chk("set_wins", req_pend[3], 1'b1);
`else
        chk("no_sticky", req_pend, 4'b0000);
`endif

        // Steady-pattern table
        tbl[0] = '{4'b0000, 12, 4'b0000};
        tbl[1] = '{4'b1010, 12, 4'b1010};
        tbl[2] = '{4'b0101, 12, 4'b0101};
        tbl[3] = '{4'b1111, 12, 4'b1111};
        tbl[4] = '{4'b0000, 12, 4'b0000};
        tbl[5] = '{4'b1111,  3, 4'b0000};
        tbl[6] = '{4'b1001, 12, 4'b1001};
        tbl[7] = '{4'b0110, 12, 4'b0110};
        for (int k = 0; k < 8; k++) begin
            sw_raw = tbl[k].raw;
            repeat (tbl[k].n) step();
            chk($sformatf("tbl%0d_sw", k), switches, tbl[k].exp_sw);
        end

        // Random traffic: a glitchy phase then a slow phase
        for (int c = 0; c < 600; c++) begin
            int div;
            div = (c < 300) ? 3 : 20;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(div - 1) == 0) sw_raw[i] = ~sw_raw[i];
            req_clr = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'b0000;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
